// File: rtl/bfm_apb_cmd_master.sv
// APB master sequencer for the PM side of the APB-to-APB bridge BFM.
// Queues read/write commands, runs each as a SETUP/ACCESS transfer and returns one response at a time.
module bfm_apb_cmd_master #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic        PCLK_PM,
    input  logic        PRESETN_PM,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        PSEL_PM,
    output logic [31:0] PADDR_PM,
    output logic        PWRITE_PM,
    output logic        PENABLE_PM,
    output logic [31:0] PWDATA_PM,
    input  logic [31:0] PRDATA_PM,
    input  logic        PREADY_PM,
    input  logic        PSLVERR_PM
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t        state_q, state_d;
    logic [64:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [64:0]   head;
    logic [TW-1:0] tcnt;
    logic          push, pop, complete, tmo;

    // Full stays full for the cycle even if a pop happens: no bypass path.
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid & cmd_ready;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state_q != ST_IDLE) | (count != '0);

    always_ff @(posedge PCLK_PM) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state: a new transfer starts only once the response slot is free or being freed.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        complete = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count != '0) && (!rsp_valid || rsp_ready)) begin
                    state_d = ST_SETUP;
                    pop     = 1'b1;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY_PM) begin
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
                    state_d = ST_IDLE;
                    tmo     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            state_q <= ST_IDLE;
            tcnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_SETUP)
                tcnt <= '0;
            else if ((state_q == ST_ACCESS) && !PREADY_PM)
                tcnt <= tcnt + 1'b1;
        end
    end

    // APB bus registers: loaded from the FIFO head, zeroed at the end of every transfer.
    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            PSEL_PM    <= 1'b0;
            PENABLE_PM <= 1'b0;
            PWRITE_PM  <= 1'b0;
            PADDR_PM   <= '0;
            PWDATA_PM  <= '0;
        end else if (pop) begin
            PSEL_PM    <= 1'b1;
            PENABLE_PM <= 1'b0;
            PWRITE_PM  <= head[64];
            PADDR_PM   <= head[63:32];
            PWDATA_PM  <= head[31:0];
        end else if (state_q == ST_SETUP) begin
            PENABLE_PM <= 1'b1;
        end else if (complete || tmo) begin
            PSEL_PM    <= 1'b0;
            PENABLE_PM <= 1'b0;
            PWRITE_PM  <= 1'b0;
            PADDR_PM   <= '0;
            PWDATA_PM  <= '0;
        end
    end

    // Response slot: a completion in the same cycle as rsp_ready overrides the clear.
    always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
        if (!PRESETN_PM) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (complete) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE_PM ? 32'h0 : PRDATA_PM;
            rsp_err     <= PSLVERR_PM;
            rsp_timeout <= 1'b0;
        end else if (tmo) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule
